// File: rtl/seg_scan_capture_if.sv
// Multiplexed 7-segment display bus: active-low segments, digit enables and decimal point.
// The scanning driver uses master; the capture monitor uses slave.
interface seg_scan_capture_if;
   logic [6:0] seg_in;
   logic [3:0] en_in;
   logic       dp_in;

   modport master (output seg_in, en_in, dp_in);
   modport slave  (input  seg_in, en_in, dp_in);
endinterface

// File: rtl/seg_scan_capture.sv
// Readback monitor for a scanned 7-segment bus: synchronises, waits for each digit to settle,
// decodes it back to a 4-bit code and publishes complete, in-order 4-digit frames.
module seg_scan_capture #(
   parameter int SETTLE  = 3,
   parameter int TIMEOUT = 4096
) (
   input  logic                clk1,
   input  logic                rst,
   seg_scan_capture_if.slave   bus,
   output logic [3:0]          digit0,
   output logic [3:0]          digit1,
   output logic [3:0]          digit2,
   output logic [3:0]          digit3,
   output logic [3:0]          dp_mask,
   output logic                frame_valid,
   output logic                frame_err,
   output logic                seg_err,
   output logic                stalled
);

   localparam int SW = $clog2(SETTLE + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef struct packed {
      logic [3:0] en;
      logic [6:0] seg;
      logic       dp;
   } bus_t;

   typedef enum logic {ST_SYNC, ST_COLLECT} state_t;

   bus_t          sync1, sync2, prev;
   logic [SW-1:0] settle_cnt;
   logic [TW-1:0] idle_cnt;
   logic          changed, en_changed, settle_evt;
   logic          one_hot;
   logic [1:0]    cap_idx;
   logic [3:0]    dec_code;
   logic          dec_bad;
   state_t        state, nxt_state;
   logic [1:0]    idx, nxt_idx;
   logic          store, publish, err;
   logic [2:0][3:0] sh_digit;
   logic [2:0]    sh_dp;
   logic          sh_bad;

   // Idle bus is all-ones (everything active-low off), so synchronisers reset to that.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk1 or negedge rst) begin
      if (!rst) begin
         sync1 <= '1;
         sync2 <= '1;
         prev  <= '1;
      end else begin
         sync1 <= {bus.en_in, bus.seg_in, bus.dp_in};
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign changed    = (sync2 != prev);
   assign en_changed = (sync2.en != prev.en);
   assign settle_evt = !changed && (settle_cnt == SW'(SETTLE - 1));
   assign stalled    = (idle_cnt == TW'(TIMEOUT));

   always_ff @(posedge clk1 or negedge rst) begin
      if (!rst) begin
         settle_cnt <= '0;
         idle_cnt   <= '0;
      end else begin
         if (changed)                          settle_cnt <= '0;
         else if (settle_cnt != SW'(SETTLE))   settle_cnt <= settle_cnt + SW'(1);
         if (en_changed)                       idle_cnt   <= '0;
         else if (!stalled)                    idle_cnt   <= idle_cnt + TW'(1);
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      one_hot = 1'b1;
      cap_idx = 2'd0;
      unique case (sync2.en)
         4'b1110: cap_idx = 2'd0;
         4'b1101: cap_idx = 2'd1;
         4'b1011: cap_idx = 2'd2;
         4'b0111: cap_idx = 2'd3;
         default: one_hot = 1'b0;
      endcase
   end

   always_comb begin
      dec_bad  = 1'b0;
      dec_code = 4'hD;
      case (sync2.seg)
         7'h40: dec_code = 4'h0;
         7'h79: dec_code = 4'h1;
         7'h24: dec_code = 4'h2;
         7'h30: dec_code = 4'h3;
         7'h19: dec_code = 4'h4;
         7'h12: dec_code = 4'h5;
         7'h02: dec_code = 4'h6;
         7'h78: dec_code = 4'h7;
         7'h00: dec_code = 4'h8;
         7'h10: dec_code = 4'h9;
         7'h7F: dec_code = 4'hF;
         7'h3F: dec_code = 4'hE;
         default: dec_bad = 1'b1;
      endcase
   end

   always_ff @(posedge clk1 or negedge rst) begin
      if (!rst) begin
         state <= ST_SYNC;
         idx   <= 2'd0;
      end else begin
         state <= nxt_state;
         idx   <= nxt_idx;
      end
   end

   // A digit0 capture always (re)starts a frame, whether from SYNC, after completion or after an error.
   always_comb begin
      nxt_state = state;
      nxt_idx   = idx;
      if (stalled) begin
         nxt_state = ST_SYNC;
      end else if (settle_evt) begin
         if (state == ST_COLLECT && one_hot && cap_idx == idx) begin
            if (idx == 2'd3) nxt_state = ST_SYNC;
            else             nxt_idx   = idx + 2'd1;
         end else if (one_hot && cap_idx == 2'd0) begin
            nxt_state = ST_COLLECT;
            nxt_idx   = 2'd1;
         end else begin
            nxt_state = ST_SYNC;
         end
      end
   end

   always_comb begin
      store   = 1'b0;
      publish = 1'b0;
      err     = 1'b0;
      if (!stalled && settle_evt) begin
         if (state == ST_COLLECT) begin
            if (one_hot && cap_idx == idx) begin
               store   = 1'b1;
               publish = (idx == 2'd3);
            end else begin
               err   = 1'b1;
               store = one_hot && (cap_idx == 2'd0);
            end
         end else begin
            store = one_hot && (cap_idx == 2'd0);
         end
      end
   end

   // NOTE: the shadow frame needs no reset; it is always rewritten from digit0 before it is published.
   always_ff @(posedge clk1) begin
      if (store) begin
         for (int i = 0; i < 3; i++) begin
            if (cap_idx == 2'(i)) begin
               sh_digit[i] <= dec_code;
               sh_dp[i]    <= ~sync2.dp;
            end
         end
         sh_bad <= (cap_idx == 2'd0) ? dec_bad : (sh_bad | dec_bad);
      end
   end

   // Digit3 is merged straight from the decoder on the completing capture.
   always_ff @(posedge clk1 or negedge rst) begin
      if (!rst) begin
         digit0      <= 4'hF;
         digit1      <= 4'hF;
         digit2      <= 4'hF;
         digit3      <= 4'hF;
         dp_mask     <= 4'b0000;
         seg_err     <= 1'b0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_valid <= publish;
         frame_err   <= err;
         if (publish) begin
            digit0  <= sh_digit[0];
            digit1  <= sh_digit[1];
            digit2  <= sh_digit[2];
            digit3  <= dec_code;
            dp_mask <= {~sync2.dp, sh_dp};
            seg_err <= sh_bad | dec_bad;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: stimulus pushes expected frame events into a queue,
// a negedge monitor pops and compares whenever frame_valid or frame_err pulses.
module tb_seg_scan_capture;
   logic       clk1 = 1'b0;
   logic       rst  = 1'b0;
   logic [3:0] digit0, digit1, digit2, digit3, dp_mask;
   logic       frame_valid, frame_err, seg_err, stalled;

   always #5 clk1 = ~clk1;

   seg_scan_capture_if bus ();

   seg_scan_capture dut (
      .clk1        (clk1),
      .rst         (rst),
      .bus         (bus),
      .digit0      (digit0),
      .digit1      (digit1),
      .digit2      (digit2),
      .digit3      (digit3),
      .dp_mask     (dp_mask),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .seg_err     (seg_err),
      .stalled     (stalled)
   );

   typedef struct {
      logic        is_err;
      logic [15:0] digits;   // {digit3, digit2, digit1, digit0}
      logic [3:0]  dp;
      logic        seg_err;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void exp_valid(input logic [15:0] d, input logic [3:0] m, input logic se);
      exp_t e;
      e.is_err = 1'b0; e.digits = d; e.dp = m; e.seg_err = se;
      sb.push_back(e);
   endfunction

   function automatic void exp_err(input logic [15:0] d);
      exp_t e;
      e.is_err = 1'b1; e.digits = d; e.dp = 4'b0000; e.seg_err = 1'b0;
      sb.push_back(e);
   endfunction

   // Monitor: decoupled from stimulus, consumes one expectation per output event.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk1);
         if (rst && (frame_valid || frame_err)) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_event: valid=%0b err=%0b, expected no event (t=%0t)",
                        frame_valid, frame_err, $time);
            end else begin
               e = sb.pop_front();
               check("event_kind", {30'd0, frame_valid, frame_err}, e.is_err ? 32'd1 : 32'd2);
               check("digits", {16'd0, digit3, digit2, digit1, digit0}, {16'd0, e.digits});
               if (!e.is_err) begin
                  check("dp_mask", {28'd0, dp_mask}, {28'd0, e.dp});
                  check("seg_err", {31'd0, seg_err}, {31'd0, e.seg_err});
               end
            end
         end
      end
   end

   task automatic drive(input logic [3:0] en, input logic [6:0] seg, input logic dp, input int n);
      bus.en_in  = en;
      bus.seg_in = seg;
      bus.dp_in  = dp;
      repeat (n) @(posedge clk1);
      #1;
   endtask

   initial begin
      bus.en_in  = 4'hF;
      bus.seg_in = 7'h7F;
      bus.dp_in  = 1'b1;
      repeat (3) @(posedge clk1);
      #1;
      check("rst_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h0000_FFFF);
      check("rst_flags", {24'd0, dp_mask, frame_valid, frame_err, seg_err, stalled}, 32'd0);
      rst = 1'b1;
      repeat (2) @(posedge clk1);
      #1;

      // Basic frame, dp lit on digit2
      drive(4'b1110, 7'h40, 1'b1, 8);
      drive(4'b1101, 7'h79, 1'b1, 8);
      drive(4'b1011, 7'h24, 1'b0, 8);
      exp_valid(16'h3210, 4'b0100, 1'b0);
      drive(4'b0111, 7'h30, 1'b1, 8);

      // Scan entered mid-cycle: nothing until the first digit0
      drive(4'b1011, 7'h24, 1'b1, 8);
      drive(4'b0111, 7'h30, 1'b1, 8);
      drive(4'b1110, 7'h12, 1'b1, 8);
      drive(4'b1101, 7'h02, 1'b1, 8);
      drive(4'b1011, 7'h78, 1'b1, 8);
      exp_valid(16'h8765, 4'b1000, 1'b0);
      drive(4'b0111, 7'h00, 1'b0, 8);

      // Skipped digit2: error, published digits untouched, next frame clean
      drive(4'b1110, 7'h10, 1'b1, 8);
      drive(4'b1101, 7'h7F, 1'b1, 8);
      exp_err(16'h8765);
      drive(4'b0111, 7'h3F, 1'b1, 8);
      drive(4'b1110, 7'h19, 1'b1, 8);
      drive(4'b1101, 7'h40, 1'b1, 8);
      drive(4'b1011, 7'h79, 1'b1, 8);
      exp_valid(16'h2104, 4'b0000, 1'b0);
      drive(4'b0111, 7'h24, 1'b1, 8);

      // Undecodable digit1, then a clean frame clears seg_err
      drive(4'b1110, 7'h40, 1'b1, 8);
      drive(4'b1101, 7'h55, 1'b1, 8);
      drive(4'b1011, 7'h3F, 1'b1, 8);
      exp_valid(16'hFED0, 4'b0000, 1'b1);
      drive(4'b0111, 7'h7F, 1'b1, 8);
      drive(4'b1110, 7'h30, 1'b1, 8);
      drive(4'b1101, 7'h30, 1'b1, 8);
      drive(4'b1011, 7'h30, 1'b1, 8);
      exp_valid(16'h3333, 4'b0000, 1'b0);
      drive(4'b0111, 7'h30, 1'b1, 8);

      // One-cycle enable glitch is filtered; a settled non-one-hot enable aborts
      drive(4'b1110, 7'h40, 1'b1, 8);
      drive(4'b1101, 7'h79, 1'b1, 3);
      drive(4'b1100, 7'h79, 1'b1, 1);
      drive(4'b1101, 7'h79, 1'b1, 8);
      drive(4'b1011, 7'h24, 1'b1, 8);
      exp_valid(16'h3210, 4'b0000, 1'b0);
      drive(4'b0111, 7'h30, 1'b1, 8);
      drive(4'b1110, 7'h40, 1'b1, 8);
      exp_err(16'h3210);
      drive(4'b1100, 7'h40, 1'b1, 5);
      drive(4'b1111, 7'h7F, 1'b1, 8);

      // Stall exactly TIMEOUT cycles after the enable change is seen, aborting silently
      drive(4'b1110, 7'h40, 1'b1, 8);
      drive(4'b1101, 7'h79, 1'b1, 4098);
      check("stall_early", {31'd0, stalled}, 32'd0);
      @(posedge clk1);
      #1;
      check("stall_set", {31'd0, stalled}, 32'd1);
      drive(4'b1011, 7'h24, 1'b1, 8);
      check("stall_clear", {31'd0, stalled}, 32'd0);
      drive(4'b0111, 7'h30, 1'b1, 8);

      // Asynchronous reset mid-frame, checked before any further clock edge
      drive(4'b1110, 7'h40, 1'b1, 8);
      drive(4'b1101, 7'h79, 1'b1, 3);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h0000_FFFF);
      check("async_rst_flags", {24'd0, dp_mask, frame_valid, frame_err, seg_err, stalled}, 32'd0);
      repeat (3) @(posedge clk1);
      #1;
      rst = 1'b1;

      drive(4'b1110, 7'h00, 1'b0, 8);
      drive(4'b1101, 7'h10, 1'b1, 8);
      drive(4'b1011, 7'h7F, 1'b1, 8);
      exp_valid(16'hEF98, 4'b0001, 1'b0);
      drive(4'b0111, 7'h3F, 1'b1, 8);
      drive(4'b1111, 7'h7F, 1'b1, 10);

      check("events_outstanding", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
